// File: rtl/instr_seq_pkg.sv
// rtl/instr_seq_pkg.sv - shared opcodes, states, field positions and widths for instr_sequencer
// INSTR_SEQ_MUL_EN selects whether opcode A is a writing MUL or illegal.
package instr_seq_pkg;

    localparam int DATA_W = 16;
    localparam int IDX_W  = 4;

    localparam int OP_MSB = 15;
    localparam int OP_LSB = 12;
    localparam int Z_MSB  = 11;
    localparam int Z_LSB  = 8;
    localparam int X_MSB  = 7;
    localparam int X_LSB  = 4;
    localparam int Y_MSB  = 3;
    localparam int Y_LSB  = 0;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_AND = 4'h3;
    localparam logic [3:0] OP_OR  = 4'h4;
    localparam logic [3:0] OP_XOR = 4'h5;
    localparam logic [3:0] OP_SHL = 4'h6;
    localparam logic [3:0] OP_SHR = 4'h7;
    localparam logic [3:0] OP_MOV = 4'h8;
    localparam logic [3:0] OP_LDI = 4'h9;
    localparam logic [3:0] OP_MUL = 4'hA;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_EXEC  = 2'd2,
        S_WRITE = 2'd3
    } state_e;

    function automatic logic op_writes(input logic [3:0] op);
`ifdef INSTR_SEQ_MUL_EN
        return (op >= OP_ADD) && (op <= OP_MUL);
`else
        return (op >= OP_ADD) && (op <= OP_LDI);
`endif
    endfunction

    function automatic logic op_illegal(input logic [3:0] op);
        return !op_writes(op) && (op != OP_NOP);
    endfunction

endpackage

// File: rtl/instr_seq_alu.sv
// rtl/instr_seq_alu.sv - combinational execute unit for instr_sequencer
// The MUL datapath exists only when INSTR_SEQ_MUL_EN is defined.
module instr_seq_alu
    import instr_seq_pkg::*;
(
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [7:0]        imm,
    output logic [DATA_W-1:0] result,
    output logic              carry
);

    logic [DATA_W:0] sum;

    assign sum = {1'b0, a} + {1'b0, b};

    always_comb begin
        result = '0;
        carry  = 1'b0;
        case (op)
            OP_ADD: begin
                result = sum[DATA_W-1:0];
                carry  = sum[DATA_W];
            end
            OP_SUB: begin
                result = a - b;
                carry  = (a < b);
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_SHL: result = a << b[3:0];
            OP_SHR: result = a >> b[3:0];
            OP_MOV: result = a;
            OP_LDI: result = {8'h00, imm};
`ifdef INSTR_SEQ_MUL_EN
            OP_MUL: result = a * b;
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - four-state read/execute/write sequencer in front of the 16-entry register file
// Build option INSTR_SEQ_MUL_EN (see instr_seq_pkg / instr_seq_alu) enables opcode A as MUL.
module instr_sequencer
    import instr_seq_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       instr,
    input  logic              instr_valid,
    output logic              instr_ready,
    output logic              RD,
    output logic [IDX_W-1:0]  x,
    output logic [IDX_W-1:0]  y,
    input  logic [DATA_W-1:0] Rx,
    input  logic [DATA_W-1:0] Ry,
    output logic              WR,
    output logic [IDX_W-1:0]  z,
    output logic [DATA_W-1:0] Rz,
    output logic              done,
    output logic              flag_z,
    output logic              flag_c,
    output logic              illegal
);

    state_e            state_q, state_d;
    logic [15:0]       instr_q, instr_d;
    logic [DATA_W-1:0] opa_q, opa_d;
    logic [DATA_W-1:0] opb_q, opb_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              carry_q, carry_d;
    logic              flag_z_q, flag_z_d;
    logic              flag_c_q, flag_c_d;
    logic              illegal_q, illegal_d;

    logic [3:0]        opcode;
    logic [DATA_W-1:0] alu_result;
    logic              alu_carry;

    assign opcode = instr_q[OP_MSB:OP_LSB];

    instr_seq_alu u_alu (
        .op     (opcode),
        .a      (opa_q),
        .b      (opb_q),
        .imm    (instr_q[7:0]),
        .result (alu_result),
        .carry  (alu_carry)
    );

    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        result_d    = result_q;
        carry_d     = carry_q;
        flag_z_d    = flag_z_q;
        flag_c_d    = flag_c_q;
        illegal_d   = illegal_q;
        instr_ready = 1'b0;
        RD          = 1'b0;
        x           = '0;
        y           = '0;
        WR          = 1'b0;
        z           = '0;
        Rz          = '0;
        done        = 1'b0;
        case (state_q)
            S_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    instr_d = instr;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                RD      = 1'b1;
                x       = instr_q[X_MSB:X_LSB];
                y       = instr_q[Y_MSB:Y_LSB];
                opa_d   = Rx;
                opb_d   = Ry;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                result_d = alu_result;
                carry_d  = alu_carry;
                state_d  = S_WRITE;
            end
            S_WRITE: begin
                done = 1'b1;
                // Flags track retirement, so they change on the WRITE edge only.
                if (op_writes(opcode)) begin
                    WR       = 1'b1;
                    z        = instr_q[Z_MSB:Z_LSB];
                    Rz       = result_q;
                    flag_z_d = (result_q == '0);
                end
                if ((opcode == OP_ADD) || (opcode == OP_SUB)) begin
                    flag_c_d = carry_q;
                end
                if (op_illegal(opcode)) begin
                    illegal_d = 1'b1;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            instr_q   <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            result_q  <= '0;
            carry_q   <= 1'b0;
            flag_z_q  <= 1'b0;
            flag_c_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            result_q  <= result_d;
            carry_q   <= carry_d;
            flag_z_q  <= flag_z_d;
            flag_c_q  <= flag_c_d;
            illegal_q <= illegal_d;
        end
    end

    assign flag_z  = flag_z_q;
    assign flag_c  = flag_c_q;
    assign illegal = illegal_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - scoreboard bench for instr_sequencer with a behavioural register file
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        RD;
    logic [3:0]  x;
    logic [3:0]  y;
    logic [15:0] Rx;
    logic [15:0] Ry;
    logic        WR;
    logic [3:0]  z;
    logic [15:0] Rz;
    logic        done;
    logic        flag_z;
    logic        flag_c;
    logic        illegal;

    always #5 clk = ~clk;

    instr_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .RD          (RD),
        .x           (x),
        .y           (y),
        .Rx          (Rx),
        .Ry          (Ry),
        .WR          (WR),
        .z           (z),
        .Rz          (Rz),
        .done        (done),
        .flag_z      (flag_z),
        .flag_c      (flag_c),
        .illegal     (illegal)
    );

    logic [15:0] rf [16];
    logic        pre_we;
    logic [3:0]  pre_idx;
    logic [15:0] pre_val;

    always @(posedge clk) begin
        if (pre_we) rf[pre_idx] <= pre_val;
        else if (WR) rf[z] <= Rz;
    end

    assign Rx = rf[x];
    assign Ry = rf[y];

    typedef struct {
        logic        wr;
        logic [3:0]  z;
        logic [15:0] rz;
        logic        fz;
        logic        fc;
        logic        ill;
    } exp_t;

    exp_t        sb[$];
    exp_t        fl;
    logic        pend = 1'b0;
    logic [15:0] mdl [16];
    logic        mfz = 1'b0;
    logic        mfc = 1'b0;
    logic        mill = 1'b0;
    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          n_acc = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset && instr_valid && instr_ready) n_acc <= n_acc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_model(input logic [15:0] ins);
        logic [3:0]  op, zi, xi, yi;
        logic [15:0] a, b, r;
        logic        c, w, il;
        exp_t        e;
        op = ins[15:12]; zi = ins[11:8]; xi = ins[7:4]; yi = ins[3:0];
        a = mdl[xi]; b = mdl[yi]; r = 16'h0; c = mfc; w = 1'b1; il = 1'b0;
        case (op)
            4'h0: w = 1'b0;
            4'h1: {c, r} = {1'b0, a} + {1'b0, b};
            4'h2: begin r = a - b; c = (a < b); end
            4'h3: r = a & b;
            4'h4: r = a | b;
            4'h5: r = a ^ b;
            4'h6: r = a << b[3:0];
            4'h7: r = a >> b[3:0];
            4'h8: r = a;
            4'h9: r = {8'h00, ins[7:0]};
            4'hA: begin
`ifdef INSTR_SEQ_MUL_EN
                r = a * b;
`else
                w = 1'b0; il = 1'b1;
`endif
            end
            default: begin w = 1'b0; il = 1'b1; end
        endcase
        if (w) begin mdl[zi] = r; mfz = (r == 16'h0); end
        if (il) mill = 1'b1;
        mfc = c;
        e.wr = w; e.z = w ? zi : 4'h0; e.rz = w ? r : 16'h0;
        e.fz = mfz; e.fc = mfc; e.ill = mill;
        sb.push_back(e);
    endtask

    task automatic preload(input logic [3:0] idx, input logic [15:0] val);
        pre_idx = idx; pre_val = val; pre_we = 1'b1; mdl[idx] = val;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    task automatic issue(input logic [15:0] ins);
        int t = 0;
        while (!instr_ready && t < 20) begin @(negedge clk); t++; end
        chk("accept_ready", instr_ready, 1);
        instr = ins; instr_valid = 1'b1;
        push_model(ins);
        @(negedge clk);
        instr_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((sb.size() != 0 || pend || !instr_ready) && t < 40) begin @(negedge clk); t++; end
        chk("idle_timeout", (t < 40), 1);
    endtask

    // Retirement monitor: compares write-port activity, then flags one cycle later.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                if (pend) begin
                    chk("flag_z", flag_z, fl.fz);
                    chk("flag_c", flag_c, fl.fc);
                    chk("illegal", illegal, fl.ill);
                    pend = 1'b0;
                end
                chk("wr_outside_retire", WR & ~done, 0);
                if (done) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_done", done, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("wr", WR, e.wr);
                        chk("z", z, e.z);
                        chk("rz", Rz, e.rz);
                        fl = e;
                        pend = 1'b1;
                    end
                end
            end else begin
                pend = 1'b0;
            end
        end
    end

    logic [15:0] prog [11];
    logic [15:0] b2b [3];
    int          acc [3];
    int          acc0;

    initial begin
        reset = 1'b0; instr = 16'h0; instr_valid = 1'b0;
        pre_we = 1'b0; pre_idx = 4'h0; pre_val = 16'h0;
        @(negedge clk);
        for (int i = 0; i < 16; i++) preload(i[3:0], 16'h0);
        chk("rst_ready", instr_ready, 1);
        chk("rst_rd", RD, 0);
        chk("rst_wr", WR, 0);
        chk("rst_done", done, 0);
        chk("rst_rz", Rz, 0);
        chk("rst_flags", {flag_z, flag_c, illegal}, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", instr_ready, 1);

        // LDI R3,0x5A with cycle-by-cycle latency checks
        issue(16'h935A);
        chk("read_rd", RD, 1);
        chk("read_x", x, 5);
        chk("read_y", y, 4'hA);
        chk("read_busy", instr_ready, 0);
        @(negedge clk);
        chk("exec_rd", {RD, x, y}, 0);
        chk("exec_done", done, 0);
        @(negedge clk);
        chk("write_done", done, 1);
        chk("write_wr", WR, 1);
        wait_idle();

        preload(4'h1, 16'hFFFF); preload(4'h2, 16'h0001);
        issue(16'h1412); wait_idle();
        preload(4'h1, 16'h0003); preload(4'h2, 16'h0005);
        issue(16'h2C12); wait_idle();
        issue(16'h6412); wait_idle();
        preload(4'h6, 16'h000F);

        prog = '{16'h3512, 16'h4612, 16'h5712, 16'h7832, 16'h7930, 16'h8A30,
                 16'h6B16, 16'h0000, 16'h9D00, 16'hB123, 16'hA912};
        for (int i = 0; i < 11; i++) begin issue(prog[i]); wait_idle(); end
        chk("illegal_sticky", illegal, mill);
        issue(16'h9E01); wait_idle();
        chk("illegal_still", illegal, mill);

        // Continuous instr_valid: three acceptances spaced four cycles apart
        b2b = '{16'h9177, 16'h1211, 16'h2321};
        acc0 = n_acc;
        instr_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            int t = 0;
            while (!instr_ready && t < 20) begin @(negedge clk); t++; end
            chk("b2b_ready", instr_ready, 1);
            acc[k] = cyc;
            instr = b2b[k];
            push_model(b2b[k]);
            @(negedge clk);
            if (k == 2) instr_valid = 1'b0;
            chk("b2b_busy_read", instr_ready, 0);
            @(negedge clk);
            chk("b2b_busy_exec", instr_ready, 0);
            @(negedge clk);
            chk("b2b_busy_write", instr_ready, 0);
        end
        wait_idle();
        chk("b2b_gap1", acc[1] - acc[0], 4);
        chk("b2b_gap2", acc[2] - acc[1], 4);
        chk("b2b_count", n_acc - acc0, 3);

        issue(16'h2412); wait_idle();
        chk("pre_reset_flag_c", flag_c, 1);

        // Reset during EXEC: no write, everything back to idle with flags clear
        instr = 16'h1112; instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("abort_wr", WR, 0);
        chk("abort_ready", instr_ready, 1);
        chk("abort_flags", {flag_z, flag_c, illegal}, 0);
        mfz = 1'b0; mfc = 1'b0; mill = 1'b0;
        @(negedge clk);
        chk("abort_wr_hold", WR, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_release_ready", instr_ready, 1);
        chk("abort_release_flags", {flag_z, flag_c, illegal}, 0);
        chk("abort_no_write", rf[1], mdl[1]);

        issue(16'h9F42); wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
